// File: rtl/gpu_font_pkg.sv
// Shared constants and FSM state encoding for the glyph fetch path.
//
// Stored glyph geometry: 64 px wide (CHAR_W_BITS), 128 px tall (CHAR_H_BITS),
// 256 glyphs per font, so consecutive fonts are 2^FONT_SHIFT bits apart.
package gpu_font_pkg;

    localparam int CHAR_W_BITS = 6;
    localparam int CHAR_H_BITS = 7;
    localparam int FONT_SHIFT  = CHAR_W_BITS + CHAR_H_BITS + 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_EMIT = 3'd4,
        S_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/glyph_addr_calc.sv
// Combinational scaled-address unit.
//
// Maps a rendered-cell offset (xo, yo) inside a w x h cell onto the stored
// 64x128 glyph so that offset 0 lands on stored pixel 0 and offset w-1 / h-1
// lands on stored pixel 63 / 127. Returns the bit address in the font bitmap.
//
// Ports:
//   idx       in   font index
//   w, h      in   rendered cell width / height (w or h of 0 or 1 gives a 0 term)
//   xo, yo    in   offset of the current pixel within the cell
//   bit_addr  out  unsigned bit address, truncated to ADDR_W
module glyph_addr_calc
    import gpu_font_pkg::*;
#(
    parameter int COORD_W = 16,
    parameter int ADDR_W  = 30
) (
    input  logic [15:0]        idx,
    input  logic [COORD_W-1:0] w,
    input  logic [COORD_W-1:0] h,
    input  logic [COORD_W-1:0] xo,
    input  logic [COORD_W-1:0] yo,
    output logic [ADDR_W-1:0]  bit_addr
);

    localparam int XN_W  = COORD_W + CHAR_W_BITS;
    localparam int YN_W  = COORD_W + CHAR_H_BITS;
    localparam int X_MAX = (1 << CHAR_W_BITS) - 1;
    localparam int Y_MAX = (1 << CHAR_H_BITS) - 1;

    logic [XN_W-1:0] x_num, x_den, x_term;
    logic [YN_W-1:0] y_num, y_den, y_term;

    always_comb begin
        x_num  = XN_W'(xo) * XN_W'(X_MAX);
        x_den  = XN_W'(w) - XN_W'(1);
        y_num  = YN_W'(yo) * YN_W'(Y_MAX);
        y_den  = YN_W'(h) - YN_W'(1);
        // A one-pixel (or empty) dimension has no span to scale over;
        // the guard also keeps the divider away from a zero divisor.
        x_term = '0;
        y_term = '0;
        if (w > COORD_W'(1)) x_term = x_num / x_den;
        if (h > COORD_W'(1)) y_term = y_num / y_den;
        bit_addr = (ADDR_W'(idx) << FONT_SHIFT)
                 + (ADDR_W'(y_term) << CHAR_W_BITS)
                 + ADDR_W'(x_term);
    end

endmodule

// File: rtl/glyph_fetch_sequencer.sv
// Glyph fetch sequencer: walks every pixel of one character cell, fetches the
// matching font byte from flash and emits one on/off pixel per cell position.
//
// Optional build macro: GLYPH_BYTE_CACHE_EN adds a one-entry byte cache so that
// pixels falling in the last fetched byte skip the flash round trip.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid / cmd_ready            draw-cell command handshake (ready only in IDLE)
//   cmd_font_idx, cmd_w, cmd_h,
//   cmd_x0, cmd_y0                   command fields, latched on acceptance
//   rd_valid / rd_ready / rd_addr    flash byte read request
//   rsp_valid / rsp_data             flash read data, one per accepted request, in order
//   px_valid / px_ready              pixel handshake to the raster writer
//   px_x, px_y, px_on                pixel screen coordinate and glyph bit
//   busy                             FSM not in IDLE
//   done                             one-cycle pulse after the last pixel is accepted
//   fsm_state                        current FSM state, for observation
//
// Handshakes: every valid/ready pair transfers on a clock edge where both are
// high; once this block raises a valid it holds it and its payload unchanged
// until that edge. rsp_valid has no ready and is only looked at in WAIT.
module glyph_fetch_sequencer
    import gpu_font_pkg::*;
#(
    parameter int COORD_W = 16,
    parameter int ADDR_W  = 30
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [15:0]         cmd_font_idx,
    input  logic [COORD_W-1:0]  cmd_w,
    input  logic [COORD_W-1:0]  cmd_h,
    input  logic [COORD_W-1:0]  cmd_x0,
    input  logic [COORD_W-1:0]  cmd_y0,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [ADDR_W-4:0]   rd_addr,
    input  logic                rsp_valid,
    input  logic [7:0]          rsp_data,
    output logic                px_valid,
    input  logic                px_ready,
    output logic [COORD_W-1:0]  px_x,
    output logic [COORD_W-1:0]  px_y,
    output logic                px_on,
    output logic                busy,
    output logic                done,
    output state_t              fsm_state
);

    state_t              state_q, state_d;
    logic [15:0]         idx_q;
    logic [COORD_W-1:0]  w_q, h_q, x0_q, y0_q;
    logic [COORD_W-1:0]  xo_q, yo_q;
    logic [ADDR_W-1:0]   addr_q, addr_calc;
    logic                px_on_q;
    logic                last_col, last_px;
    logic                cache_hit;
    logic [7:0]          cache_byte;

    glyph_addr_calc #(
        .COORD_W (COORD_W),
        .ADDR_W  (ADDR_W)
    ) u_addr_calc (
        .idx      (idx_q),
        .w        (w_q),
        .h        (h_q),
        .xo       (xo_q),
        .yo       (yo_q),
        .bit_addr (addr_calc)
    );

    assign last_col = (xo_q == w_q - COORD_W'(1));
    assign last_px  = last_col && (yo_q == h_q - COORD_W'(1));

`ifdef GLYPH_BYTE_CACHE_EN
    logic               cache_valid;
    logic [ADDR_W-4:0]  cache_tag;
    logic [7:0]         cache_data;

    assign cache_hit  = cache_valid && (cache_tag == addr_calc[ADDR_W-1:3]);
    assign cache_byte = cache_data;

    // Refilled from every flash response; forgotten on each new command so a
    // stale byte never leaks across cells.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
        end else if (state_q == S_IDLE && cmd_valid) begin
            cache_valid <= 1'b0;
        end else if (state_q == S_WAIT && rsp_valid) begin
            cache_valid <= 1'b1;
            cache_tag   <= addr_q[ADDR_W-1:3];
            cache_data  <= rsp_data;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_byte = 8'h00;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (cmd_valid) begin
                state_d = (cmd_w == '0 || cmd_h == '0) ? S_DONE : S_CALC;
            end
            S_CALC: state_d = cache_hit ? S_EMIT : S_REQ;
            S_REQ:  if (rd_ready)  state_d = S_WAIT;
            S_WAIT: if (rsp_valid) state_d = S_EMIT;
            S_EMIT: if (px_ready)  state_d = last_px ? S_DONE : S_CALC;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            w_q     <= '0;
            h_q     <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            addr_q  <= '0;
            px_on_q <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: if (cmd_valid) begin
                    idx_q <= cmd_font_idx;
                    w_q   <= cmd_w;
                    h_q   <= cmd_h;
                    x0_q  <= cmd_x0;
                    y0_q  <= cmd_y0;
                    xo_q  <= '0;
                    yo_q  <= '0;
                end
                S_CALC: begin
                    addr_q <= addr_calc;
                    if (cache_hit) px_on_q <= cache_byte[addr_calc[2:0]];
                end
                S_WAIT: if (rsp_valid) px_on_q <= rsp_data[addr_q[2:0]];
                S_EMIT: if (px_ready) begin
                    // Raster order; after the last pixel the counters are left
                    // as they are, the next command reloads them.
                    if (last_col) begin
                        xo_q <= '0;
                        yo_q <= yo_q + COORD_W'(1);
                    end else begin
                        xo_q <= xo_q + COORD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rd_valid  = (state_q == S_REQ);
    assign px_valid  = (state_q == S_EMIT);
    assign done      = (state_q == S_DONE);
    assign rd_addr   = addr_q[ADDR_W-1:3];
    assign px_x      = x0_q + xo_q;
    assign px_y      = y0_q + yo_q;
    assign px_on     = px_on_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_glyph_fetch_sequencer.sv
module tb_glyph_fetch_sequencer;
    import gpu_font_pkg::*;

    localparam int COORD_W = 16;
    localparam int ADDR_W  = 30;
    localparam int BA_W    = ADDR_W - 3;
`ifdef GLYPH_BYTE_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [15:0]        cmd_font_idx = '0;
    logic [COORD_W-1:0] cmd_w = '0, cmd_h = '0, cmd_x0 = '0, cmd_y0 = '0;
    logic               rd_valid;
    logic               rd_ready = 1'b1;
    logic [BA_W-1:0]    rd_addr;
    logic               rsp_valid = 1'b0;
    logic [7:0]         rsp_data = '0;
    logic               px_valid;
    logic               px_ready = 1'b1;
    logic [COORD_W-1:0] px_x, px_y;
    logic               px_on;
    logic               busy;
    logic               done;
    state_t             fsm_state;

    glyph_fetch_sequencer #(.COORD_W(COORD_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_font_idx (cmd_font_idx),
        .cmd_w        (cmd_w),
        .cmd_h        (cmd_h),
        .cmd_x0       (cmd_x0),
        .cmd_y0       (cmd_y0),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_addr      (rd_addr),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .px_valid     (px_valid),
        .px_ready     (px_ready),
        .px_x         (px_x),
        .px_y         (px_y),
        .px_on        (px_on),
        .busy         (busy),
        .done         (done),
        .fsm_state    (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [BA_W-1:0] exp_rd_q[$];
    logic [32:0]     exp_px_q[$];   // {x, y, on}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Flash contents: arbitrary but fixed pattern, byte 0 holds 8'h01.
    function automatic logic [7:0] flash_byte(input logic [BA_W-1:0] a);
        if (a == '0) return 8'h01;
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h96;
    endfunction

    // Reference scaled bit address, straight from the formula.
    function automatic logic [ADDR_W-1:0] model_bit(input logic [15:0] idx, input int w, input int h,
                                                    input int xo, input int yo);
        longint xt, yt, a;
        xt = (w <= 1) ? 0 : (longint'(xo) * 63) / longint'(w - 1);
        yt = (h <= 1) ? 0 : (longint'(yo) * 127) / longint'(h - 1);
        a  = (longint'(idx) << 21) + (yt << 6) + xt;
        return a[ADDR_W-1:0];
    endfunction

    // ---------------- flash / raster bus model ----------------
    int              rd_stall = 0, px_stall = 0;
    bit              junk_rsp = 1'b0;
    bit              rsp_pend = 1'b0;
    logic [BA_W-1:0] rsp_addr = '0;
    bit              rd_hold = 1'b0, px_hold = 1'b0;
    logic [BA_W-1:0] prev_rd = '0;
    logic [32:0]     prev_px = '0;
    int              rd_count = 0, px_count = 0;
    logic [BA_W-1:0] rd_first = '0, rd_last = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rsp_valid = 1'b0;
            rsp_pend  = 1'b0;
            rd_hold   = 1'b0;
            px_hold   = 1'b0;
            rd_ready  = 1'b1;
            px_ready  = 1'b1;
        end else begin
            // Response for a request accepted at the previous edge; optional
            // junk responses in every other cycle must be ignored.
            rsp_valid = 1'b0;
            rsp_data  = 8'h00;
            if (rsp_pend) begin
                rsp_valid = 1'b1;
                rsp_data  = flash_byte(rsp_addr);
                rsp_pend  = 1'b0;
            end else if (junk_rsp) begin
                rsp_valid = 1'b1;
                rsp_data  = 8'hA5;
            end

            if (rd_valid) begin
                if (rd_hold) check("rd_addr_stable", 64'(rd_addr), 64'(prev_rd));
                if (rd_stall > 0) begin
                    rd_ready = 1'b0;
                    rd_stall--;
                    rd_hold  = 1'b1;
                    prev_rd  = rd_addr;
                end else begin
                    rd_ready = 1'b1;
                    rd_hold  = 1'b0;
                    rd_count++;
                    if (rd_count == 1) rd_first = rd_addr;
                    rd_last = rd_addr;
                    if (exp_rd_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rd_extra actual=%0h expected=none", rd_addr);
                    end else begin
                        check("rd_addr", 64'(rd_addr), 64'(exp_rd_q.pop_front()));
                    end
                    rsp_pend = 1'b1;
                    rsp_addr = rd_addr;
                end
            end else begin
                rd_ready = 1'b1;
                rd_hold  = 1'b0;
            end

            if (px_valid) begin
                if (px_hold) check("px_stable", 64'({px_x, px_y, px_on}), 64'(prev_px));
                if (px_stall > 0) begin
                    px_ready = 1'b0;
                    px_stall--;
                    px_hold  = 1'b1;
                    prev_px  = {px_x, px_y, px_on};
                end else begin
                    px_ready = 1'b1;
                    px_hold  = 1'b0;
                    px_count++;
                    if (exp_px_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL px_extra actual=%0h expected=none", {px_x, px_y, px_on});
                    end else begin
                        check("px_xy_on", 64'({px_x, px_y, px_on}), 64'(exp_px_q.pop_front()));
                    end
                end
            end else begin
                px_ready = 1'b1;
                px_hold  = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_cell(input logic [15:0] idx, input int w, input int h,
                              input logic [15:0] x0, input logic [15:0] y0);
        logic [ADDR_W-1:0] a;
        logic [BA_W-1:0]   b, last_b;
        logic [7:0]        byt;
        logic [15:0]       ex, ey;
        bit                last_v;
        exp_rd_q.delete();
        exp_px_q.delete();
        rd_count = 0;
        px_count = 0;
        last_v   = 1'b0;
        last_b   = '0;
        for (int yo = 0; yo < h; yo++) begin
            for (int xo = 0; xo < w; xo++) begin
                a = model_bit(idx, w, h, xo, yo);
                b = a[ADDR_W-1:3];
                if (!CACHE || !last_v || b != last_b) exp_rd_q.push_back(b);
                last_b = b;
                last_v = 1'b1;
                byt = flash_byte(b);
                ex  = x0 + 16'(xo);
                ey  = y0 + 16'(yo);
                exp_px_q.push_back({ex, ey, byt[a[2:0]]});
            end
        end
        @(negedge clk);
        check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        cmd_font_idx = idx;
        cmd_w        = 16'(w);
        cmd_h        = 16'(h);
        cmd_x0       = x0;
        cmd_y0       = y0;
        cmd_valid    = 1'b1;
        @(negedge clk);
        // Command is taken; scramble the fields, they must not matter now.
        cmd_valid    = 1'b0;
        cmd_font_idx = 16'($urandom);
        cmd_w        = 16'($urandom_range(1, 40));
        cmd_h        = 16'($urandom_range(1, 40));
        cmd_x0       = 16'($urandom);
        cmd_y0       = 16'($urandom);
        check("busy_after_accept", 64'(busy), 64'(1));
        check("cmd_ready_busy", 64'(cmd_ready), 64'(0));
    endtask

    task automatic finish_cell(input int npx, input int nrd, input logic [BA_W-1:0] first,
                               input logic [BA_W-1:0] last, input int extra);
        int cyc = 1;
        int limit;
        limit = 10 * npx + 64 + extra;
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 64'(done), 64'(1));
        check("cell_cycles", 64'(cyc), 64'(2 * npx + 2 * nrd + 1 + extra));
        check("busy_in_done", 64'(busy), 64'(1));
        check("rd_count", 64'(rd_count), 64'(nrd));
        check("px_count", 64'(px_count), 64'(npx));
        check("rd_q_left", 64'(exp_rd_q.size()), 64'(0));
        check("px_q_left", 64'(exp_px_q.size()), 64'(0));
        if (nrd > 0) begin
            check("rd_first", 64'(rd_first), 64'(first));
            check("rd_last", 64'(rd_last), 64'(last));
        end
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'(0));
        check("idle_after_done", 64'(cmd_ready), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
        check({tag, "_rd_valid"},  64'(rd_valid),  64'(0));
        check({tag, "_px_valid"},  64'(px_valid),  64'(0));
        check({tag, "_busy"},      64'(busy),      64'(0));
        check({tag, "_done"},      64'(done),      64'(0));
        check({tag, "_rd_addr"},   64'(rd_addr),   64'(0));
        check({tag, "_px_xy_on"},  64'({px_x, px_y, px_on}), 64'(0));
        check({tag, "_state"},     64'(fsm_state), 64'(S_IDLE));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0]     idx;
        int              w, h;
        logic [15:0]     x0, y0;
        int              nrd_nc, nrd_c;
        logic [BA_W-1:0] first, last;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int nrd;
        int n;
        vecs[0] = '{16'd0,     1,   1, 16'd10,    16'd20,       1,    1, 27'h0,       27'h0};
        vecs[1] = '{16'd1,     64, 128, 16'd100,  16'd200,   8192, 1024, 27'h40000,   27'h403FF};
        vecs[2] = '{16'd5,     0,   5, 16'd1,     16'd1,        0,    0, 27'h0,       27'h0};
        vecs[3] = '{16'd3,     7,   0, 16'd2,     16'd2,        0,    0, 27'h0,       27'h0};
        vecs[4] = '{16'd2,     3,   2, 16'hFFFE,  16'hFFFF,     6,    6, 27'h80000,   27'h803FF};
        vecs[5] = '{16'h03FF,  1,   3, 16'd0,     16'd0,        3,    3, 27'h7FC0000, 27'h7FC03F8};
        vecs[6] = '{16'd0,     8,   1, 16'd30,    16'd40,       8,    8, 27'h0,       27'h7};
        vecs[7] = '{16'd0,     16,  1, 16'd50,    16'd60,      16,    8, 27'h0,       27'h7};

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven cells.
        for (int i = 0; i < 8; i++) begin
            nrd = CACHE ? vecs[i].nrd_c : vecs[i].nrd_nc;
            start_cell(vecs[i].idx, vecs[i].w, vecs[i].h, vecs[i].x0, vecs[i].y0);
            finish_cell(vecs[i].w * vecs[i].h, nrd, vecs[i].first, vecs[i].last, 0);
        end

        // Back-pressure: 5 cycles of rd_ready low, 3 of px_ready low, with
        // spurious rsp_valid outside WAIT.
        rd_stall = 5;
        px_stall = 3;
        junk_rsp = 1'b1;
        start_cell(16'd4, 2, 1, 16'd5, 16'd6);
        finish_cell(2, 2, 27'h100000, 27'h100007, 8);
        junk_rsp = 1'b0;
        @(negedge clk);

        // Reset while waiting for the third pixel's data.
        start_cell(16'd0, 4, 1, 16'd7, 16'd8);
        n = 0;
        while (!(rd_count >= 3 && fsm_state == S_WAIT) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_third_wait", 64'(fsm_state), 64'(S_WAIT));
        check("px_before_reset", 64'(px_count), 64'(2));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        check("no_done_in_reset", 64'(done), 64'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");
        start_cell(16'd0, 4, 1, 16'd7, 16'd8);
        finish_cell(4, 4, 27'h0, 27'h7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
